// File: rtl/parser_recovery_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : parser_recovery_ctrl_if
// Description : Bundle of the parser-side and RX-FIFO-side signals seen by
//               the parser recovery controller.
//               slave  modport : the recovery controller
//               master modport : the parser / RX path driving it
//   wdt_en           ctrl -> : 1 = timeout detection armed
//   parser_state[3:0] ctrl -> : parser state code (0 IDLE .. 9 ERROR_STATE)
//   frame_valid_hold ctrl -> : parser frame-valid flag
//   rx_byte_valid    ctrl -> : byte delivered to parser this cycle
//   rx_fifo_empty    ctrl -> : RX FIFO empty
//   stats_clr        ctrl -> : clear recovery statistics
//   parser_abort     -> ctrl : one-cycle pulse forcing parser to IDLE
//   rx_fifo_flush    -> ctrl : RX FIFO discard request (level)
//   rx_hold          -> ctrl : blocks RX FIFO pops to the parser (level)
//   busy             -> ctrl : recovery sequence in progress
//   timeout_cause[1:0] -> ctrl : 01 byte stall, 10 VALIDATE stuck
//   recovery_count[7:0] -> ctrl : saturating recovery counter
// Revision    : 1.0 - initial release
// ============================================================================
interface parser_recovery_ctrl_if;
    logic       wdt_en;
    logic [3:0] parser_state;
    logic       frame_valid_hold;
    logic       rx_byte_valid;
    logic       rx_fifo_empty;
    logic       stats_clr;
    logic       parser_abort;
    logic       rx_fifo_flush;
    logic       rx_hold;
    logic       busy;
    logic [1:0] timeout_cause;
    logic [7:0] recovery_count;

    modport slave (
        input  wdt_en,
        input  parser_state,
        input  frame_valid_hold,
        input  rx_byte_valid,
        input  rx_fifo_empty,
        input  stats_clr,
        output parser_abort,
        output rx_fifo_flush,
        output rx_hold,
        output busy,
        output timeout_cause,
        output recovery_count
    );

    modport master (
        output wdt_en,
        output parser_state,
        output frame_valid_hold,
        output rx_byte_valid,
        output rx_fifo_empty,
        output stats_clr,
        input  parser_abort,
        input  rx_fifo_flush,
        input  rx_hold,
        input  busy,
        input  timeout_cause,
        input  recovery_count
    );
endinterface
`default_nettype wire

// File: rtl/parser_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parser_recovery_ctrl
// Description : Watchdog and recovery sequencer for the frame parser.
//               In MONITOR it times byte stalls in the active parser states
//               (CMD, ADDR_BYTE0-3, DATA_RX, CRC_RX, ERROR_STATE) and a stuck
//               frame_valid_hold in VALIDATE. On a timeout it runs
//               ABORT (one-cycle parser_abort) -> FLUSH (until the RX FIFO
//               reports empty) -> COOLDOWN (COOLDOWN_CYCLES of rx_hold)
//               and returns to MONITOR.
// Ports       : clk, rst (synchronous, active-high)
//               bus : parser_recovery_ctrl_if.slave (see interface header)
// Parameters  : BYTE_TIMEOUT_CYCLES, VALIDATE_TIMEOUT_CYCLES,
//               COOLDOWN_CYCLES (all >= 2)
// Options     : PARSER_RECOVERY_STATS_EN - when defined, recovery_count and
//               timeout_cause are live statistics; otherwise they are tied
//               to zero and stats_clr is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module parser_recovery_ctrl #(
    parameter int BYTE_TIMEOUT_CYCLES     = 1024,
    parameter int VALIDATE_TIMEOUT_CYCLES = 512,
    parameter int COOLDOWN_CYCLES         = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    parser_recovery_ctrl_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_STALL_W = $clog2(BYTE_TIMEOUT_CYCLES + 1);
    localparam int c_HOLD_W  = $clog2(VALIDATE_TIMEOUT_CYCLES + 1);
    localparam int c_COOL_W  = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [c_STALL_W-1:0] c_STALL_LIMIT = c_STALL_W'(BYTE_TIMEOUT_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LIMIT  = c_HOLD_W'(VALIDATE_TIMEOUT_CYCLES - 1);
    localparam logic [c_COOL_W-1:0]  c_COOL_LIMIT  = c_COOL_W'(COOLDOWN_CYCLES - 1);

    localparam logic [3:0] c_PS_IDLE     = 4'd0;
    localparam logic [3:0] c_PS_VALIDATE = 4'd8;

    localparam logic [1:0] c_CAUSE_STALL    = 2'b01;
    localparam logic [1:0] c_CAUSE_VALIDATE = 2'b10;

    typedef enum logic [1:0] {
        S_MONITOR  = 2'd0,
        S_ABORT    = 2'd1,
        S_FLUSH    = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_prev_state;
    logic [c_STALL_W-1:0]   r_stall_cnt;
    logic [c_HOLD_W-1:0]    r_hold_cnt;
    logic [c_COOL_W-1:0]    r_cool_cnt;

    logic w_in_idle;
    logic w_in_validate;
    logic w_state_changed;
    logic w_stall_clear;
    logic w_hold_active;
    logic w_byte_timeout;
    logic w_val_timeout;
    logic w_monitor;

    // ------------------------------------------------------------------------
    // Timeout detection
    // ------------------------------------------------------------------------
    assign w_monitor       = (r_state == S_MONITOR);
    assign w_in_idle       = (bus.parser_state == c_PS_IDLE);
    assign w_in_validate   = (bus.parser_state == c_PS_VALIDATE);
    assign w_state_changed = (bus.parser_state != r_prev_state);

    // Any sign of parser progress restarts the stall window. VALIDATE has its
    // own hold timer, so the stall counter is parked there to avoid wrapping
    // during a long legitimate validation.
    assign w_stall_clear = w_in_idle | w_in_validate | w_state_changed |
                           bus.rx_byte_valid | ~bus.wdt_en;

    assign w_hold_active = w_in_validate & bus.frame_valid_hold & bus.wdt_en;

    // The limit compare only matters on a stalling cycle, so progress in the
    // same cycle as the limit suppresses the timeout.
    assign w_byte_timeout = w_monitor & ~w_stall_clear & (r_stall_cnt == c_STALL_LIMIT);
    assign w_val_timeout  = w_monitor & w_hold_active  & (r_hold_cnt  == c_HOLD_LIMIT);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_MONITOR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        bus.parser_abort  = 1'b0;
        bus.rx_fifo_flush = 1'b0;
        bus.rx_hold       = 1'b0;
        bus.busy          = 1'b0;

        case (r_state)
            S_MONITOR: begin
                if (w_byte_timeout || w_val_timeout) begin
                    w_state_nxt = S_ABORT;
                end
            end
            S_ABORT: begin
                bus.parser_abort = 1'b1;
                bus.rx_hold      = 1'b1;
                bus.busy         = 1'b1;
                w_state_nxt      = S_FLUSH;
            end
            S_FLUSH: begin
                bus.rx_fifo_flush = 1'b1;
                bus.rx_hold       = 1'b1;
                bus.busy          = 1'b1;
                if (bus.rx_fifo_empty) begin
                    w_state_nxt = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                bus.rx_hold = 1'b1;
                bus.busy    = 1'b1;
                if (r_cool_cnt == c_COOL_LIMIT) begin
                    w_state_nxt = S_MONITOR;
                end
            end
            default: begin
                w_state_nxt = S_MONITOR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters. Both watchdog counters are held at zero outside MONITOR so the
    // controller always re-enters MONITOR with a fresh window.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_state <= c_PS_IDLE;
            r_stall_cnt  <= '0;
            r_hold_cnt   <= '0;
            r_cool_cnt   <= '0;
        end else begin
            r_prev_state <= bus.parser_state;

            if (!w_monitor || (w_state_nxt != S_MONITOR) || w_stall_clear) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (!w_monitor || (w_state_nxt != S_MONITOR) || !w_hold_active) begin
                r_hold_cnt <= '0;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            if ((r_state == S_COOLDOWN) && (w_state_nxt == S_COOLDOWN)) begin
                r_cool_cnt <= r_cool_cnt + 1'b1;
            end else begin
                r_cool_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Recovery statistics
    // ------------------------------------------------------------------------
`ifdef PARSER_RECOVERY_STATS_EN
    logic [7:0] r_recovery_count;
    logic [1:0] r_timeout_cause;

    // stats_clr takes priority over a recovery landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_recovery_count <= '0;
            r_timeout_cause  <= '0;
        end else if (bus.stats_clr) begin
            r_recovery_count <= '0;
            r_timeout_cause  <= '0;
        end else begin
            if ((r_state == S_ABORT) && (r_recovery_count != 8'hFF)) begin
                r_recovery_count <= r_recovery_count + 1'b1;
            end
            if (w_byte_timeout) begin
                r_timeout_cause <= c_CAUSE_STALL;
            end else if (w_val_timeout) begin
                r_timeout_cause <= c_CAUSE_VALIDATE;
            end
        end
    end

    assign bus.recovery_count = r_recovery_count;
    assign bus.timeout_cause  = r_timeout_cause;
`else
    logic w_unused_stats;
    assign w_unused_stats     = bus.stats_clr | (|c_CAUSE_STALL) | (|c_CAUSE_VALIDATE);
    assign bus.recovery_count = 8'd0;
    assign bus.timeout_cause  = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parser_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_parser_recovery_ctrl
// Description : Self-checking bench for parser_recovery_ctrl with
//               BYTE_TIMEOUT=16, VALIDATE_TIMEOUT=8, COOLDOWN=4. Expected
//               abort latencies and causes are queued when the stall is
//               started and popped when parser_abort is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parser_recovery_ctrl;

    localparam int BT = 16;
    localparam int VT = 8;
    localparam int CD = 4;
`ifdef PARSER_RECOVERY_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    parser_recovery_ctrl_if bus ();

    parser_recovery_ctrl #(
        .BYTE_TIMEOUT_CYCLES     (BT),
        .VALIDATE_TIMEOUT_CYCLES (VT),
        .COOLDOWN_CYCLES         (CD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        logic [1:0] cause;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] model_cnt = 8'd0;
    logic [1:0] model_cause = 2'b00;

    // Reference statistics: what the counters should read with stats enabled.
    task automatic model_recovery(input logic [1:0] c);
        if (model_cnt != 8'd255) model_cnt = model_cnt + 8'd1;
        model_cause = c;
    endtask

    function automatic logic [7:0] exp_cnt();
        return STATS ? model_cnt : 8'd0;
    endfunction

    function automatic logic [1:0] exp_cause();
        return STATS ? model_cause : 2'b00;
    endfunction

    task automatic push_exp(input int lat, input logic [1:0] c);
        exp_t e;
        model_recovery(c);
        e.lat   = lat;
        e.cause = exp_cause();
        sb_q.push_back(e);
    endtask

    // Returns the number of falling edges until parser_abort is seen, or -1.
    task automatic wait_abort(input int max_cyc, output int k);
        k = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (bus.parser_abort === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    // Returns the number of falling edges until busy drops, or -1.
    task automatic wait_idle(input int max_cyc, output int k);
        k = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.parser_abort, bus.rx_fifo_flush, bus.rx_hold, bus.busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl_outputs: got %b, want 0000",
                     {bus.parser_abort, bus.rx_fifo_flush, bus.rx_hold, bus.busy});
        end
        n_vec++;
        if ({bus.timeout_cause, bus.recovery_count} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_stats: got cause=%b count=%0d, want 0/0",
                     bus.timeout_cause, bus.recovery_count);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_busy: got %b, want 0", bus.busy);
        end
    endtask

    task automatic test_byte_stall(input logic [3:0] ps, input string tag);
        exp_t e;
        int   k;
        @(negedge clk);
        bus.parser_state = ps;
        push_exp(BT + 1, 2'b01);
        wait_abort(BT + 20, k);
        e = sb_q.pop_front();
        n_vec++;
        if (k !== e.lat) begin
            n_err++;
            $display("FAIL %s_abort_latency: got %0d, want %0d", tag, k, e.lat);
        end
        n_vec++;
        if (bus.timeout_cause !== e.cause) begin
            n_err++;
            $display("FAIL %s_cause: got %b, want %b", tag, bus.timeout_cause, e.cause);
        end
        bus.parser_state = 4'd0;
        @(negedge clk);
        n_vec++;
        if ({bus.parser_abort, bus.rx_fifo_flush, bus.rx_hold} !== 3'b011) begin
            n_err++;
            $display("FAIL %s_abort_pulse: got abort/flush/hold=%b, want 011", tag,
                     {bus.parser_abort, bus.rx_fifo_flush, bus.rx_hold});
        end
        n_vec++;
        if (bus.recovery_count !== exp_cnt()) begin
            n_err++;
            $display("FAIL %s_count: got %0d, want %0d", tag, bus.recovery_count, exp_cnt());
        end
        wait_idle(CD + 20, k);
        n_vec++;
        if (k !== CD + 1) begin
            n_err++;
            $display("FAIL %s_recovery_len: got %0d, want %0d", tag, k, CD + 1);
        end
    endtask

    task automatic test_byte_valid_wins();
        exp_t e;
        int   k;
        @(negedge clk);
        bus.parser_state = 4'd3;
        push_exp(2 * BT + 1, 2'b01);
        k = -1;
        for (int i = 1; i <= 3 * BT; i++) begin
            @(negedge clk);
            if (bus.parser_abort === 1'b1) begin
                k = i;
                break;
            end
            bus.rx_byte_valid = (i == BT);
        end
        bus.rx_byte_valid = 1'b0;
        e = sb_q.pop_front();
        n_vec++;
        if (k !== e.lat) begin
            n_err++;
            $display("FAIL byte_valid_wins_latency: got %0d, want %0d", k, e.lat);
        end
        bus.parser_state = 4'd0;
        wait_idle(CD + 20, k);
        n_vec++;
        if (k !== CD + 2) begin
            n_err++;
            $display("FAIL byte_valid_wins_recovery_len: got %0d, want %0d", k, CD + 2);
        end
    endtask

    task automatic test_wdt_disable();
        exp_t e;
        int   k;
        int   aborts = 0;
        @(negedge clk);
        bus.wdt_en       = 1'b0;
        bus.parser_state = 4'd5;
        for (int i = 1; i <= 3 * BT; i++) begin
            @(negedge clk);
            if (bus.parser_abort === 1'b1) aborts++;
        end
        n_vec++;
        if (aborts !== 0) begin
            n_err++;
            $display("FAIL wdt_disabled_aborts: got %0d, want 0", aborts);
        end
        // Re-arming starts a fresh window that counts from this cycle.
        bus.wdt_en = 1'b1;
        push_exp(BT, 2'b01);
        wait_abort(BT + 20, k);
        e = sb_q.pop_front();
        n_vec++;
        if (k !== e.lat) begin
            n_err++;
            $display("FAIL wdt_rearm_latency: got %0d, want %0d", k, e.lat);
        end
        bus.parser_state = 4'd0;
        wait_idle(CD + 20, k);
    endtask

    task automatic test_validate();
        exp_t e;
        int   k;
        int   aborts = 0;
        // Hold drops after VT-1 cycles: must not time out.
        @(negedge clk);
        bus.parser_state     = 4'd8;
        bus.frame_valid_hold = 1'b1;
        for (int i = 1; i <= VT + 10; i++) begin
            @(negedge clk);
            if (bus.parser_abort === 1'b1) aborts++;
            bus.frame_valid_hold = (i < VT - 1);
        end
        n_vec++;
        if (aborts !== 0) begin
            n_err++;
            $display("FAIL validate_short_aborts: got %0d, want 0", aborts);
        end
        bus.parser_state = 4'd0;
        @(negedge clk);
        bus.parser_state     = 4'd8;
        bus.frame_valid_hold = 1'b1;
        push_exp(VT, 2'b10);
        wait_abort(VT + 20, k);
        e = sb_q.pop_front();
        n_vec++;
        if (k !== e.lat) begin
            n_err++;
            $display("FAIL validate_latency: got %0d, want %0d", k, e.lat);
        end
        n_vec++;
        if (bus.timeout_cause !== e.cause) begin
            n_err++;
            $display("FAIL validate_cause: got %b, want %b", bus.timeout_cause, e.cause);
        end
        bus.parser_state     = 4'd0;
        bus.frame_valid_hold = 1'b0;
        wait_idle(CD + 20, k);
        n_vec++;
        if (k !== CD + 2) begin
            n_err++;
            $display("FAIL validate_recovery_len: got %0d, want %0d", k, CD + 2);
        end
    endtask

    task automatic test_flush_cooldown();
        exp_t e;
        int   k;
        int   flush_cycles = 0;
        int   release_at   = -1;
        @(negedge clk);
        bus.rx_fifo_empty = 1'b0;
        bus.parser_state  = 4'd4;
        push_exp(BT + 1, 2'b01);
        wait_abort(BT + 20, k);
        e = sb_q.pop_front();
        n_vec++;
        if (k !== e.lat) begin
            n_err++;
            $display("FAIL flush_abort_latency: got %0d, want %0d", k, e.lat);
        end
        bus.parser_state = 4'd0;
        bus.wdt_en       = 1'b0;   // disarming mid-recovery must not shorten it
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.rx_fifo_flush === 1'b1) flush_cycles++;
            if (bus.rx_hold === 1'b0) begin
                release_at = i;
                break;
            end
            if (i == 6) bus.rx_fifo_empty = 1'b1;
        end
        bus.wdt_en = 1'b1;
        n_vec++;
        if (flush_cycles !== 6) begin
            n_err++;
            $display("FAIL flush_cycles: got %0d, want 6", flush_cycles);
        end
        n_vec++;
        if (release_at !== 1 + 6 + CD) begin
            n_err++;
            $display("FAIL hold_release: got %0d, want %0d", release_at, 1 + 6 + CD);
        end
    endtask

    task automatic test_reset_mid_flush();
        int k;
        @(negedge clk);
        bus.rx_fifo_empty = 1'b0;
        bus.parser_state  = 4'd2;
        model_recovery(2'b01);
        wait_abort(BT + 20, k);
        bus.parser_state = 4'd0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.rx_fifo_flush !== 1'b1) begin
            n_err++;
            $display("FAIL in_flush: got flush=%b (abort wait %0d), want 1", bus.rx_fifo_flush, k);
        end
        rst = 1'b1;
        @(negedge clk);
        model_cnt   = 8'd0;
        model_cause = 2'b00;
        n_vec++;
        if ({bus.parser_abort, bus.rx_fifo_flush, bus.rx_hold, bus.busy,
             bus.timeout_cause, bus.recovery_count} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_mid_flush: got %b, want all zero",
                     {bus.parser_abort, bus.rx_fifo_flush, bus.rx_hold, bus.busy,
                      bus.timeout_cause, bus.recovery_count});
        end
        rst = 1'b0;
        bus.rx_fifo_empty = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset_monitor: got busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_saturation_and_clear();
        int k;
        int k2;
        int timeouts = 0;
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            bus.parser_state     = 4'd8;
            bus.frame_valid_hold = 1'b1;
            model_recovery(2'b10);
            wait_abort(VT + 10, k);
            bus.parser_state     = 4'd0;
            bus.frame_valid_hold = 1'b0;
            wait_idle(CD + 20, k2);
            if (k < 0 || k2 < 0) timeouts++;
        end
        n_vec++;
        if (timeouts !== 0) begin
            n_err++;
            $display("FAIL saturation_recoveries: got %0d timeouts, want 0", timeouts);
        end
        n_vec++;
        if (bus.recovery_count !== exp_cnt()) begin
            n_err++;
            $display("FAIL saturation_count: got %0d, want %0d", bus.recovery_count, exp_cnt());
        end
        // stats_clr while ABORT is incrementing: the clear must win.
        @(negedge clk);
        bus.parser_state     = 4'd8;
        bus.frame_valid_hold = 1'b1;
        model_recovery(2'b10);
        wait_abort(VT + 10, k);
        bus.parser_state     = 4'd0;
        bus.frame_valid_hold = 1'b0;
        bus.stats_clr        = 1'b1;
        model_cnt   = 8'd0;
        model_cause = 2'b00;
        @(negedge clk);
        bus.stats_clr = 1'b0;
        n_vec++;
        if ({bus.recovery_count, bus.timeout_cause} !== {exp_cnt(), exp_cause()}) begin
            n_err++;
            $display("FAIL stats_clr: got count=%0d cause=%b (abort wait %0d), want %0d/%b",
                     bus.recovery_count, bus.timeout_cause, k, exp_cnt(), exp_cause());
        end
        wait_idle(CD + 20, k2);
        n_vec++;
        if (bus.recovery_count !== 8'd0) begin
            n_err++;
            $display("FAIL stats_clr_hold: got %0d, want 0", bus.recovery_count);
        end
    endtask

    initial begin
        rst                  = 1'b1;
        bus.wdt_en           = 1'b1;
        bus.parser_state     = 4'd0;
        bus.frame_valid_hold = 1'b0;
        bus.rx_byte_valid    = 1'b0;
        bus.rx_fifo_empty    = 1'b1;
        bus.stats_clr        = 1'b0;

        test_reset();
        test_byte_stall(4'd2, "byte_stall");
        test_byte_valid_wins();
        test_validate();
        test_byte_stall(4'd9, "error_state");
        test_wdt_disable();
        test_flush_cooldown();
        test_reset_mid_flush();
        test_saturation_and_clear();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, want completion");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
